pc_stack: RTL and testbench

//  Parametrised successor to the Hack program counter: reset/load/inc plus a

---
 rtl/pc_stack_pkg.sv | 45 ++++
 rtl/pc_stack_if.sv | 37 +++
 rtl/pc_stack_ret_stack.sv | 70 +++++++
 rtl/pc_stack.sv | 100 ++++++++++
 tb/tb_pc_stack.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_stack_pkg.sv
// rtl/pc_stack_pkg.sv - shared defaults, action encoding and helpers for pc_stack
package pc_stack_pkg;

  localparam int unsigned PC_W_DEFAULT      = 16;
  localparam int unsigned DEPTH_DEFAULT     = 4;
  localparam int unsigned RESET_VEC_DEFAULT = 0;

  // One action per edge, highest priority first:
  //   clr > call > ret > load > inc > hold
  // Lower-priority requests in the same cycle are dropped silently.
  typedef enum logic [2:0] {
    ACT_HOLD = 3'd0,
    ACT_INC  = 3'd1,
    ACT_LOAD = 3'd2,
    ACT_RET  = 3'd3,
    ACT_CALL = 3'd4,
    ACT_CLR  = 3'd5
  } pc_act_e;

  // Bits needed to hold values 0..n-1 (minimum 1 so a 1-entry stack still has a depth bit).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

  // Resolve the simultaneous request lines into the single action taken this edge.
  function automatic pc_act_e pick_action(input logic clr, input logic call,
                                          input logic ret, input logic load,
                                          input logic inc);
    pc_act_e a;
    if (clr)       a = ACT_CLR;
    else if (call) a = ACT_CALL;
    else if (ret)  a = ACT_RET;
    else if (load) a = ACT_LOAD;
    else if (inc)  a = ACT_INC;
    else           a = ACT_HOLD;
    return a;
  endfunction

endpackage

// File: rtl/pc_stack_if.sv
// rtl/pc_stack_if.sv - decoder-to-PC control and status bundle
interface pc_stack_if
  import pc_stack_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4
) ();

  localparam int DW = clog2(DEPTH + 1);

  logic          clr;
  logic          load;
  logic          inc;
  logic          call;
  logic          ret;
  logic          clr_err;
  logic [W-1:0]  in;
  logic [W-1:0]  out;
  logic [DW-1:0] depth;
  logic          empty;
  logic          full;
  logic          ovf;
  logic          unf;

  // Decoder side: issues requests, observes PC and stack status.
  modport master (
    output clr, load, inc, call, ret, clr_err, in,
    input  out, depth, empty, full, ovf, unf
  );

  // PC side: consumes requests, reports PC and stack status.
  modport slave (
    input  clr, load, inc, call, ret, clr_err, in,
    output out, depth, empty, full, ovf, unf
  );

endinterface

// File: rtl/pc_stack_ret_stack.sv
// rtl/pc_stack_ret_stack.sv - return-address LIFO with depth/full/empty status
module ret_stack
  import pc_stack_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  localparam int DW   = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  top_data,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] depth_q, depth_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign full  = (depth_q == DW'(DEPTH));
  assign empty = (depth_q == '0);
  assign depth = depth_q;

  // Accept only legal operations; push wins if both arrive (the top never issues both).
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush && !push;

  // Top-of-stack read as a scan so non-power-of-2 depths need no out-of-range index.
  always_comb begin
    top_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(depth_q) == i + 1) top_data = mem_q[i];
    end
  end

  // Next depth and next storage contents.
  always_comb begin
    depth_d = depth_q;
    mem_d   = mem_q;
    if (flush) begin
      depth_d = '0;
    end else if (push_ok) begin
      depth_d = depth_q + DW'(1);
      for (int i = 0; i < DEPTH; i++) begin
        if (int'(depth_q) == i) mem_d[i] = push_data;
      end
    end else if (pop_ok) begin
      depth_d = depth_q - DW'(1);
    end
  end

  // Depth register; reset empties the stack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) depth_q <= '0;
    else        depth_q <= depth_d;
  end

  // Storage contents carry no reset; they are meaningless until pushed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_stack.sv
// rtl/pc_stack.sv - program counter with hardware call/return stack and sticky error flags
module pc_stack
  import pc_stack_pkg::*;
#(
  parameter int W               = 16,
  parameter int DEPTH           = 4,
  parameter logic [W-1:0] RESET_VEC = W'(RESET_VEC_DEFAULT)
) (
  input  logic     clk,
  input  logic     reset,
  pc_stack_if.slave bus
);

  localparam int DW = clog2(DEPTH + 1);

  pc_act_e       act;
  logic [W-1:0]  out_q, out_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [W-1:0]  ret_addr;
  logic [W-1:0]  top_data;
  logic [DW-1:0] stk_depth;
  logic          stk_full;
  logic          stk_empty;
  logic          push;
  logic          pop;
  logic          flush;

  // Single action for this edge from the prioritised request lines.
  always_comb begin
    act = pick_action(bus.clr, bus.call, bus.ret, bus.load, bus.inc);
  end

  assign ret_addr = out_q + W'(1);
  assign flush    = (act == ACT_CLR);
  assign push     = (act == ACT_CALL) && !stk_full;
  assign pop      = (act == ACT_RET) && !stk_empty;

  ret_stack #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .push_data (ret_addr),
    .top_data  (top_data),
    .depth     (stk_depth),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Next PC and sticky flags; a flag set on the same edge as clr_err stays set.
  always_comb begin
    out_d = out_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (bus.clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    unique case (act)
      ACT_CLR:  out_d = RESET_VEC;
      ACT_CALL: begin
        if (stk_full) ovf_d = 1'b1;
        else          out_d = bus.in;
      end
      ACT_RET: begin
        if (stk_empty) unf_d = 1'b1;
        else           out_d = top_data;
      end
      ACT_LOAD: out_d = bus.in;
      ACT_INC:  out_d = ret_addr;
      default:  out_d = out_q;
    endcase
  end

  // PC and flag registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= RESET_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.depth = stk_depth;
  assign bus.empty = stk_empty;
  assign bus.full  = stk_full;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// tb/tb_pc_stack.sv - randomized and directed self-checking bench for pc_stack
module tb_pc_stack;

  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;

  pc_stack_if #(.W(W), .DEPTH(DEPTH)) bus ();

  pc_stack #(.W(W), .DEPTH(DEPTH), .RESET_VEC(16'h0000)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: PC value, return stack as a queue, sticky flags.
  logic [15:0] m_out;
  logic [15:0] m_stk[$];
  logic        m_ovf;
  logic        m_unf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 16'h0000;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input logic c_clr, input logic c_load, input logic c_inc,
                            input logic c_call, input logic c_ret, input logic c_err,
                            input logic [15:0] c_in);
    if (c_err) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (c_clr) begin
      m_out = 16'h0000;
      m_stk.delete();
    end else if (c_call) begin
      if (m_stk.size() == DEPTH) m_ovf = 1'b1;
      else begin
        m_stk.push_back(16'((32'(m_out) + 1) % 65536));
        m_out = c_in;
      end
    end else if (c_ret) begin
      if (m_stk.size() == 0) m_unf = 1'b1;
      else m_out = m_stk.pop_back();
    end else if (c_load) begin
      m_out = c_in;
    end else if (c_inc) begin
      m_out = 16'((32'(m_out) + 1) % 65536);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out"},   32'(bus.out),   32'(m_out));
    check({tag, ".depth"}, 32'(bus.depth), 32'(m_stk.size()));
    check({tag, ".empty"}, 32'(bus.empty), 32'(m_stk.size() == 0));
    check({tag, ".full"},  32'(bus.full),  32'(m_stk.size() == DEPTH));
    check({tag, ".ovf"},   32'(bus.ovf),   32'(m_ovf));
    check({tag, ".unf"},   32'(bus.unf),   32'(m_unf));
  endtask

  task automatic idle_inputs();
    bus.clr = 0; bus.load = 0; bus.inc = 0; bus.call = 0; bus.ret = 0; bus.clr_err = 0;
    bus.in = '0;
  endtask

  // Apply one set of requests across one rising edge, then check everything.
  task automatic cycle(input string tag, input logic c_clr, input logic c_load,
                       input logic c_inc, input logic c_call, input logic c_ret,
                       input logic c_err, input logic [15:0] c_in);
    bus.clr = c_clr; bus.load = c_load; bus.inc = c_inc;
    bus.call = c_call; bus.ret = c_ret; bus.clr_err = c_err; bus.in = c_in;
    @(posedge clk);
    model_step(c_clr, c_load, c_inc, c_call, c_ret, c_err, c_in);
    #1;
    idle_inputs();
    check_all(tag);
  endtask

  logic [15:0] neg_val;

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // 1: inc x3, load negative value, async reset mid-cycle
    cycle("inc1", 0, 0, 1, 0, 0, 0, 16'h0);
    cycle("inc2", 0, 0, 1, 0, 0, 0, 16'h0);
    cycle("inc3", 0, 0, 1, 0, 0, 0, 16'h0);
    check("inc3_const", 32'(bus.out), 32'd3);
    neg_val = 16'(-32123);
    cycle("load_neg", 0, 1, 0, 0, 0, 0, neg_val);
    check("load_neg_const", 32'(bus.out), 32'd33413);
    cycle("call_pre_rst", 0, 0, 0, 1, 0, 0, 16'd77);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst.out", 32'(bus.out), 32'd0);
    check("async_rst.depth", 32'(bus.depth), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("after_rst");

    // 2: nested call/return
    cycle("load100", 0, 1, 0, 0, 0, 0, 16'd100);
    cycle("call500", 0, 0, 0, 1, 0, 0, 16'd500);
    check("call500_const", 32'(bus.out), 32'd500);
    cycle("call900", 0, 0, 0, 1, 0, 0, 16'd900);
    check("call900_depth", 32'(bus.depth), 32'd2);
    cycle("ret1", 0, 0, 0, 0, 1, 0, 16'd0);
    check("ret1_const", 32'(bus.out), 32'd501);
    cycle("ret2", 0, 0, 0, 0, 1, 0, 16'd0);
    check("ret2_const", 32'(bus.out), 32'd101);
    check("ret2_empty", 32'(bus.empty), 32'd1);

    // 3: overflow
    for (int i = 0; i < 4; i++) cycle("fill", 0, 0, 0, 1, 0, 0, 16'(10 * (i + 1)));
    check("fill_full", 32'(bus.full), 32'd1);
    cycle("call_ovf", 0, 0, 0, 1, 0, 0, 16'd7);
    check("ovf_set", 32'(bus.ovf), 32'd1);
    check("ovf_out_hold", 32'(bus.out), 32'd40);
    check("ovf_depth", 32'(bus.depth), 32'd4);
    cycle("clr_err_ovf", 0, 0, 0, 0, 0, 1, 16'd0);
    check("ovf_cleared", 32'(bus.ovf), 32'd0);
    cycle("clr_full", 1, 0, 0, 0, 0, 0, 16'd0);

    // 4: underflow, ret beats load/inc
    cycle("load55", 0, 1, 0, 0, 0, 0, 16'd55);
    cycle("ret_unf", 0, 0, 0, 0, 1, 0, 16'd0);
    check("unf_set", 32'(bus.unf), 32'd1);
    cycle("ret_load_inc", 0, 1, 1, 0, 1, 0, 16'd999);
    check("ret_wins_out", 32'(bus.out), 32'd55);
    cycle("err_and_unf", 0, 0, 0, 0, 1, 1, 16'd0);
    check("set_beats_clear", 32'(bus.unf), 32'd1);
    cycle("clr_err_unf", 0, 0, 0, 0, 0, 1, 16'd0);

    // 5: wraparound
    cycle("loadffff", 0, 1, 0, 0, 0, 0, 16'hFFFF);
    cycle("inc_wrap", 0, 0, 1, 0, 0, 0, 16'd0);
    check("inc_wrap_const", 32'(bus.out), 32'd0);
    cycle("loadffff2", 0, 1, 0, 0, 0, 0, 16'hFFFF);
    cycle("call_wrap", 0, 0, 0, 1, 0, 0, 16'd5);
    cycle("ret_wrap", 0, 0, 0, 0, 1, 0, 16'd0);
    check("ret_wrap_const", 32'(bus.out), 32'd0);
    cycle("set_unf", 0, 0, 0, 0, 1, 0, 16'd0);

    // 6: call beats ret/load; clr keeps flags
    cycle("load10", 0, 1, 0, 0, 0, 0, 16'd10);
    cycle("call_ret_load", 0, 1, 0, 1, 1, 0, 16'd200);
    check("call_only_out", 32'(bus.out), 32'd200);
    check("call_only_depth", 32'(bus.depth), 32'd1);
    cycle("call300", 0, 0, 0, 1, 0, 0, 16'd300);
    cycle("call400", 0, 0, 0, 1, 0, 0, 16'd400);
    cycle("clr_d3", 1, 0, 1, 1, 0, 0, 16'd123);
    check("clr_out", 32'(bus.out), 32'd0);
    check("clr_depth", 32'(bus.depth), 32'd0);
    check("clr_keeps_unf", 32'(bus.unf), 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic r_clr, r_load, r_inc, r_call, r_ret, r_err;
      logic [15:0] r_in;
      r_clr  = ($urandom_range(31) == 0);
      r_call = ($urandom_range(3) == 0);
      r_ret  = ($urandom_range(3) == 0);
      r_load = ($urandom_range(7) == 0);
      r_inc  = ($urandom_range(1) == 0);
      r_err  = ($urandom_range(15) == 0);
      r_in   = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
      cycle("rand", r_clr, r_load, r_inc, r_call, r_ret, r_err, r_in);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
